// File: rtl/micro_sequencer.sv
// micro_sequencer -- next-address generator for the microprogrammed control unit.
//
// Holds the microprogram counter (upc), decodes the sequencing op of the
// current microword and drives addr/jmpc into the external MPC select mux.
// The mux result comes back on mpc_in and becomes the next upc.
//
// Optional feature macro: USEQ_STACK_EN enables the CALL/RET return stack.
// Without it CALL acts as JMP, RET acts as SEQ and stk_err is tied low.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   mpc_in      next address selected by the MPC mux
//   uw_next     next-address field of the current microword
//   uw_op       sequencing op (0 SEQ,1 JMP,2 BRZ,3 BRNZ,4 DISPATCH,5 CALL,6 RET,7 HALT)
//   z           ALU zero flag for the current microcycle
//   stall       freezes all state while high
//   resume      single-cycle pulse that leaves HALT
//   addr, jmpc  to the MPC mux (jmpc=1 selects IR)
//   upc         registered control-store address
//   halted      high while in HALT
//   stk_err     sticky stack overflow/underflow flag
module micro_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mpc_in,
  input  logic [ADDR_W-1:0] uw_next,
  input  logic [2:0]        uw_op,
  input  logic              z,
  input  logic              stall,
  input  logic              resume,
  output logic [ADDR_W-1:0] addr,
  output logic              jmpc,
  output logic [ADDR_W-1:0] upc,
  output logic              halted,
  output logic              stk_err
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [2:0] OP_SEQ  = 3'd0, OP_JMP  = 3'd1, OP_BRZ  = 3'd2, OP_BRNZ = 3'd3,
                         OP_DISP = 3'd4, OP_CALL = 3'd5, OP_RET  = 3'd6, OP_HALT = 3'd7;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] inc;

  assign inc    = upc + ADDR_W'(1);  // wraps naturally at 2^ADDR_W
  assign halted = (state == HALT);

`ifdef USEQ_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stk;
  logic [SP_W-1:0]                    sp;   // number of valid entries
  logic [ADDR_W-1:0]                  tos;
  logic                               full, empty, push, pop, err_set;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);

  // Top-of-stack read as a select loop so an empty pointer never indexes out of range.
  always_comb begin
    tos = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (SP_W'(i + 1) == sp) tos = stk[i];
  end
`endif

  // Next-address decode. addr never depends on mpc_in, so the loop through the
  // external mux stays a single combinational pass.
  always_comb begin
    addr     = inc;
    jmpc     = 1'b0;
    state_nx = state;
`ifdef USEQ_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
`endif
    if (state == HALT) begin
      addr = upc;
      if (resume) state_nx = RUN;
    end else begin
      case (uw_op)
        OP_SEQ:  addr = inc;
        OP_JMP:  addr = uw_next;
        OP_BRZ:  addr = z ? uw_next : inc;
        OP_BRNZ: addr = z ? inc : uw_next;
        OP_DISP: jmpc = 1'b1;              // addr stays inc, ignored by the mux
        OP_CALL: begin
          addr = uw_next;                  // jump is taken even if the push is dropped
`ifdef USEQ_STACK_EN
          if (full) err_set = 1'b1;
          else      push    = 1'b1;
`endif
        end
        OP_RET: begin
`ifdef USEQ_STACK_EN
          if (empty) err_set = 1'b1;       // underflow falls through to inc
          else begin
            addr = tos;
            pop  = 1'b1;
          end
`endif
        end
        OP_HALT: begin
          addr     = upc;
          state_nx = HALT;
        end
        default: addr = inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      upc   <= '0;
    end else if (!stall) begin
      state <= state_nx;
      if (state == RUN)  upc <= mpc_in;
      else if (resume)   upc <= '0;
    end
  end

`ifdef USEQ_STACK_EN
  // Push/pop share the edge that loads upc; stall defers them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp      <= '0;
      stk     <= '0;
      stk_err <= 1'b0;
    end else if (!stall) begin
      if (err_set) stk_err <= 1'b1;
      if (push) begin
        for (int i = 0; i < STACK_DEPTH; i++)
          if (SP_W'(i) == sp) stk[i] <= inc;
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
    end
  end
`else
  assign stk_err = 1'b0;
`endif

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address generator for the microprogrammed control unit. It holds the microprogram counter register `upc`, decodes the sequencing field of the current microword, and drives `addr` and `jmpc` into the MPC select mux. The mux's selected result returns on `mpc_in` and is registered as the next `upc`, which addresses the control store. The block adds conditional branching, opcode dispatch, stall hold, halt/resume, and an optional microcode subroutine stack.

## Interface
- `ADDR_W`, 8, microaddress width; equals the width of the IR and of the MPC mux path.
- `STACK_DEPTH`, 4, number of return-address entries; only meaningful with `USEQ_STACK_EN`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mpc_in`  in  ADDR_W  selected next address returned by the MPC mux.
- `uw_next`  in  ADDR_W  next-address field of the current microword.
- `uw_op`  in  3  sequencing op of the current microword.
- `z`  in  1  ALU zero flag, valid during the current microcycle.
- `stall`  in  1  memory wait; freezes all state while high.
- `resume`  in  1  single-cycle pulse that leaves HALT.
- `addr`  out  ADDR_W  to the MPC mux `Addr` input.
- `jmpc`  out  1  to the MPC mux `JMPC` input; 1 selects IR.
- `upc`  out  ADDR_W  registered control-store address.
- `halted`  out  1  high while in HALT.
- `stk_err`  out  1  sticky stack overflow/underflow flag.

## Operation
- `inc` = `upc + 1`, computed modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
- `uw_op` decode in RUN; `addr` and `jmpc` are combinational:
  - 0 SEQ: `addr` = `inc`, `jmpc` = 0.
  - 1 JMP: `addr` = `uw_next`, `jmpc` = 0.
  - 2 BRZ: `addr` = `uw_next` if `z`, else `inc`; `jmpc` = 0.
  - 3 BRNZ: `addr` = `uw_next` if `!z`, else `inc`; `jmpc` = 0.
  - 4 DISPATCH: `jmpc` = 1, `addr` = `inc`. The `addr` value is don't-care to the mux but is driven deterministically.
  - 5 CALL: push `inc` onto the stack, `addr` = `uw_next`.
  - 6 RET: `addr` = top of stack, pop.
  - 7 HALT: `addr` = `upc`, `jmpc` = 0; go to HALT next edge.
- States:
  - RUN: `upc` <= `mpc_in` on each edge with `stall` = 0.
  - HALT: `upc` held; `addr` = `upc`; `jmpc` = 0; `halted` = 1. `resume` = 1 sets `upc` <= 0 and returns to RUN. The stack is preserved.
- `stall` = 1 in any state: `upc`, the state, the stack pointer, the stack contents and `stk_err` are all held. `addr` and `jmpc` still reflect the current decode. A pending push or pop executes on the first edge with `stall` = 0.
- CALL with the stack full: the push is dropped, the jump to `uw_next` is still taken, and `stk_err` <= 1.
- RET with the stack empty: `addr` = `inc`, no pop, and `stk_err` <= 1.
- `stk_err` clears only on reset.
- `resume` while in RUN is ignored.

## Timing
- Reset, asserted asynchronously:
  - `upc` = 0, state = RUN, stack pointer = 0, `stk_err` = 0, `halted` = 0.
  - With `uw_op` = SEQ: `addr` = 1, `jmpc` = 0.
- Reset asserted in the middle of a stall, a CALL or HALT clears state immediately. The first active edge after release loads `mpc_in`.
- Latency: `upc` updates one cycle after the microword is presented.
  - `addr` -> `mpc_in` -> `upc` is a single-cycle combinational loop through the external mux.
  - There is no combinational path from `mpc_in` to `addr`.
- CALL/RET:
  - Push and pop take effect on the same edge that loads `upc`.
  - RET in the cycle right after CALL returns the value just pushed.
- Entering HALT: `halted` rises on the edge that registers the HALT op. It falls on the edge that samples `resume` = 1.

## Configuration
- `USEQ_STACK_EN` defined:
  - The stack is implemented as STACK_DEPTH x ADDR_W registers with a pointer.
  - CALL and RET behave as described in Operation.
- `USEQ_STACK_EN` undefined:
  - No stack storage is implemented.
  - CALL behaves as JMP and RET behaves as SEQ.
  - `stk_err` is tied to 0.

## Test plan
- Reset, then three SEQ ops with the loop closed through a `jmpc`-select mux model -> `upc` = 0, 1, 2, 3. Then force `upc` = 8'hFF and SEQ -> `upc` = 8'h00.
- BRZ `uw_next` = 8'h40 with `z` = 1 -> `upc` = 8'h40. BRZ with `z` = 0 from `upc` = 8'h10 -> `upc` = 8'h11. BRNZ mirrors both cases.
- DISPATCH with IR = 8'hA5 in the mux model -> `jmpc` = 1, `upc` = 8'hA5 the next cycle.
- `USEQ_STACK_EN`:
  - CALL 8'h80 from `upc` = 8'h05, then RET -> `upc` = 8'h80, then 8'h06.
  - Five nested CALLs -> `stk_err` = 1 after the fifth.
  - RET with the stack empty -> `stk_err` = 1, `upc` = `inc`.
- `stall` held 3 cycles during a CALL -> `upc` and the stack pointer are unchanged for 3 cycles. The push happens on the first unstalled edge.
- HALT at `upc` = 8'h22 -> `halted` = 1 and `upc` stays 8'h22 for 10 cycles. A `resume` pulse -> `upc` = 0, `halted` = 0. `rst_n` low mid-HALT -> `upc` = 0 immediately.
